// File: rtl/online_residual_engine_pkg.sv
// Shared digit encodings and FSM state codes for the online residual engine.
package online_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/online_residual_engine_if.sv
// Step/result bus of the online residual engine; res_ovf only exists with ONLINE_RES_OVF_EN.
interface online_residual_engine_if #(
  parameter int UPPER_WIDTH = 5
);
  logic                   start;
  logic                   in_valid;
  logic [UPPER_WIDTH-1:0] v_plus_int;
  logic [UPPER_WIDTH-1:0] v_minus_int;
  logic                   compare_frac;
  logic [1:0]             shift_in;
  logic [UPPER_WIDTH-1:0] w_plus_int;
  logic [UPPER_WIDTH-1:0] w_minus_int;
  logic [1:0]             p_value;
  logic                   out_valid;
  logic                   busy;
  logic                   done;
`ifdef ONLINE_RES_OVF_EN
  logic                   res_ovf;
`endif

  modport master (
    output start, in_valid, v_plus_int, v_minus_int, compare_frac, shift_in,
`ifdef ONLINE_RES_OVF_EN
    input  res_ovf,
`endif
    input  w_plus_int, w_minus_int, p_value, out_valid, busy, done
  );

  modport slave (
    input  start, in_valid, v_plus_int, v_minus_int, compare_frac, shift_in,
`ifdef ONLINE_RES_OVF_EN
    output res_ovf,
`endif
    output w_plus_int, w_minus_int, p_value, out_valid, busy, done
  );

endinterface

// File: rtl/online_residual_engine_sel.sv
// Digit selection from an estimate of the top residual bits (optional ONLINE_RES_OVF_EN extreme flag).
module online_sel_fn
  import online_pkg::*;
#(
  parameter int UPPER_WIDTH = 5,
  parameter int EST_BITS    = 3
) (
  input  logic [UPPER_WIDTH-1:0] v_plus_int,
  input  logic [UPPER_WIDTH-1:0] v_minus_int,
  input  logic                   compare_frac,
`ifdef ONLINE_RES_OVF_EN
  output logic                   est_extreme,
`endif
  output logic [1:0]             sel
);

  localparam logic signed [EST_BITS-1:0] EST_ZERO  = '0;
  localparam logic signed [EST_BITS-1:0] EST_MINUS = '1;

  logic [UPPER_WIDTH-1:0]     v_upper;
  logic signed [EST_BITS-1:0] est;

  assign v_upper = v_plus_int - v_minus_int - {{(UPPER_WIDTH-1){1'b0}}, compare_frac};
  assign est     = v_upper[UPPER_WIDTH-1 -: EST_BITS];

  // Estimates of 0 and -1 both map to a zero digit, keeping the residual bounded.
  always_comb begin
    sel = SD_ZERO;
    if (est > EST_ZERO)
      sel = SD_POS;
    else if (est < EST_MINUS)
      sel = SD_NEG;
  end

`ifdef ONLINE_RES_OVF_EN
  localparam logic signed [EST_BITS-1:0] EST_MAX = {1'b0, {(EST_BITS-1){1'b1}}};
  localparam logic signed [EST_BITS-1:0] EST_MIN = {1'b1, {(EST_BITS-1){1'b0}}};

  assign est_extreme = (est == EST_MAX) || (est == EST_MIN);
`endif

endmodule

// File: rtl/online_residual_engine.sv
// Online residual engine: IDLE/DELAY/RUN/DONE sequencing of residual updates and digit output.
// Build option ONLINE_RES_OVF_EN adds a sticky res_ovf flag for extreme estimates.
module online_residual_engine
  import online_pkg::*;
#(
  parameter int UPPER_WIDTH  = 5,
  parameter int EST_BITS     = 3,
  parameter int ONLINE_DELAY = 3,
  parameter int NUM_DIGITS   = 16
) (
  input logic                     clk,
  input logic                     asyn_reset,
  online_residual_engine_if.slave bus
);

  localparam int         W          = UPPER_WIDTH;
  localparam logic [7:0] DELAY_LAST = 8'(ONLINE_DELAY - 1);
  localparam logic [7:0] RUN_LAST   = 8'(NUM_DIGITS - 1);
  localparam logic [1:0] FIRST_ST   = (ONLINE_DELAY == 0) ? ST_RUN : ST_DELAY;

  logic [1:0]   state;
  logic [7:0]   step_cnt;
  logic [W-1:0] w_plus_q, w_minus_q;
  logic [1:0]   p_value_q;
  logic         out_valid_q;
  logic [1:0]   sel, d;
  logic         msb_keep;
  logic [W-1:0] w_plus_next, w_minus_next;

  online_sel_fn #(
    .UPPER_WIDTH (UPPER_WIDTH),
    .EST_BITS    (EST_BITS)
  ) u_sel (
    .v_plus_int   (bus.v_plus_int),
    .v_minus_int  (bus.v_minus_int),
    .compare_frac (bus.compare_frac),
`ifdef ONLINE_RES_OVF_EN
    .est_extreme  (est_extreme),
`endif
    .sel          (sel)
  );

  // Leading DELAY steps shift the residual with a forced zero digit.
  assign d = (state == ST_RUN) ? sel : SD_ZERO;

  assign msb_keep     = bus.v_plus_int[W-2] ^ bus.v_minus_int[W-2] ^ d[1] ^ d[0];
  assign w_plus_next  = {msb_keep & (bus.v_plus_int[W-2] ^ d[1]),
                         bus.v_plus_int[W-3:0], bus.shift_in[1]};
  assign w_minus_next = {msb_keep & (bus.v_minus_int[W-2] ^ d[0]),
                         bus.v_minus_int[W-3:0], bus.shift_in[0]};

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state       <= ST_IDLE;
      step_cnt    <= '0;
      w_plus_q    <= '0;
      w_minus_q   <= '0;
      p_value_q   <= SD_ZERO;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state     <= FIRST_ST;
            step_cnt  <= '0;
            w_plus_q  <= '0;
            w_minus_q <= '0;
            p_value_q <= SD_ZERO;
          end
        end
        ST_DELAY: begin
          if (bus.in_valid) begin
            w_plus_q  <= w_plus_next;
            w_minus_q <= w_minus_next;
            if (step_cnt == DELAY_LAST) begin
              state    <= ST_RUN;
              step_cnt <= '0;
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
        end
        ST_RUN: begin
          if (bus.in_valid) begin
            w_plus_q    <= w_plus_next;
            w_minus_q   <= w_minus_next;
            p_value_q   <= d;
            out_valid_q <= 1'b1;
            if (step_cnt == RUN_LAST) begin
              state    <= ST_DONE;
              step_cnt <= '0;
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ONLINE_RES_OVF_EN
  logic est_extreme;
  logic res_ovf_q;

  // Sticky until the next honoured start.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset)
      res_ovf_q <= 1'b0;
    else if (state == ST_IDLE && bus.start)
      res_ovf_q <= 1'b0;
    else if (state == ST_RUN && bus.in_valid && est_extreme)
      res_ovf_q <= 1'b1;
  end

  assign bus.res_ovf = res_ovf_q;
`endif

  assign bus.w_plus_int  = w_plus_q;
  assign bus.w_minus_int = w_minus_q;
  assign bus.p_value     = p_value_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = (state == ST_DELAY) || (state == ST_RUN);
  assign bus.done        = (state == ST_DONE);

endmodule

// File: tb/tb_online_residual_engine.sv
// Directed-vector bench for online_residual_engine (UPPER_WIDTH=5, EST_BITS=3, ONLINE_DELAY=2, NUM_DIGITS=4).
module tb_online_residual_engine;

  localparam int W = 5;

  logic clk = 1'b0;
  logic asyn_reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  online_residual_engine_if #(.UPPER_WIDTH(W)) bus ();

  online_residual_engine #(
    .UPPER_WIDTH  (W),
    .EST_BITS     (3),
    .ONLINE_DELAY (2),
    .NUM_DIGITS   (4)
  ) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] wp, input logic [W-1:0] wm,
                           input logic [1:0] p, input logic ov, input logic bsy, input logic dn);
    check_output({tag, "/w_plus"},    8'(bus.w_plus_int),  8'(wp));
    check_output({tag, "/w_minus"},   8'(bus.w_minus_int), 8'(wm));
    check_output({tag, "/p_value"},   8'(bus.p_value),     8'(p));
    check_output({tag, "/out_valid"}, 8'(bus.out_valid),   8'(ov));
    check_output({tag, "/busy"},      8'(bus.busy),        8'(bsy));
    check_output({tag, "/done"},      8'(bus.done),        8'(dn));
  endtask

  // Present one cycle of inputs, then sample 1 time unit after the edge.
  task automatic apply_stimulus(input logic st, input logic iv, input logic [W-1:0] vp,
                                input logic [W-1:0] vm, input logic cf, input logic [1:0] si);
    bus.start        = st;
    bus.in_valid     = iv;
    bus.v_plus_int   = vp;
    bus.v_minus_int  = vm;
    bus.compare_frac = cf;
    bus.shift_in     = si;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.v_plus_int = '0;
    bus.v_minus_int = '0; bus.compare_frac = 1'b0; bus.shift_in = 2'b00;
    asyn_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 5'b00000, 5'b00000, 2'b00, 1'b0, 1'b0, 1'b0);
`ifdef ONLINE_RES_OVF_EN
    check_output("reset/res_ovf", 8'(bus.res_ovf), 8'd0);
`endif
    asyn_reset = 1'b0;

    // Operation 1: delay steps, stall, then the three selection cases.
    apply_stimulus(1, 0, 5'b00000, 5'b00000, 0, 2'b00);
    check_all("start1", 5'b00000, 5'b00000, 2'b00, 0, 1, 0);
    apply_stimulus(0, 1, 5'b01000, 5'b00000, 0, 2'b10);
    check_all("delay1", 5'b10001, 5'b00000, 2'b00, 0, 1, 0);
    apply_stimulus(0, 1, 5'b00000, 5'b00000, 0, 2'b00);
    check_all("delay2", 5'b00000, 5'b00000, 2'b00, 0, 1, 0);
    apply_stimulus(0, 1, 5'b01000, 5'b00000, 0, 2'b10);
    check_all("run_pos", 5'b00001, 5'b00000, 2'b10, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 5'b11111, 5'b10101, 1, 2'b11);
      check_all("stall", 5'b00001, 5'b00000, 2'b10, 0, 1, 0);
    end
    apply_stimulus(0, 1, 5'b00000, 5'b00110, 1, 2'b00);
    check_all("run_neg", 5'b00000, 5'b11100, 2'b01, 1, 1, 0);
    apply_stimulus(0, 1, 5'b00011, 5'b00011, 1, 2'b00);
    check_all("run_zero", 5'b00110, 5'b00110, 2'b00, 1, 1, 0);
    apply_stimulus(0, 1, 5'b00000, 5'b00000, 0, 2'b11);
    check_all("run_last", 5'b00001, 5'b00001, 2'b00, 1, 0, 1);
`ifdef ONLINE_RES_OVF_EN
    check_output("op1/res_ovf", 8'(bus.res_ovf), 8'd0);
`endif
    apply_stimulus(0, 1, 5'b01000, 5'b00000, 0, 2'b10);
    check_all("done_ignore", 5'b00001, 5'b00001, 2'b00, 0, 0, 0);

    // Start with in_valid in IDLE: honoured start, no step taken.
    apply_stimulus(1, 1, 5'b01000, 5'b00000, 0, 2'b10);
    check_all("start_valid", 5'b00000, 5'b00000, 2'b00, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, 1, 5'b01000, 5'b00000, 0, 2'b10);
      check_all($sformatf("burst%0d", i), (i >= 2) ? 5'b00001 : 5'b10001, 5'b00000,
                (i >= 2) ? 2'b10 : 2'b00, (i >= 2), (i < 5), (i == 5));
    end
    apply_stimulus(0, 1, 5'b00000, 5'b00110, 1, 2'b00);
    check_all("burst_extra", 5'b00001, 5'b00000, 2'b10, 0, 0, 0);

    // Extreme estimate in RUN (sets res_ovf where built in).
    apply_stimulus(1, 0, 5'b00000, 5'b00000, 0, 2'b00);
    apply_stimulus(0, 1, 5'b00000, 5'b00000, 0, 2'b00);
    apply_stimulus(0, 1, 5'b00000, 5'b00000, 0, 2'b00);
    apply_stimulus(0, 1, 5'b01100, 5'b00000, 0, 2'b00);
    check_all("run_max", 5'b01000, 5'b00000, 2'b10, 1, 1, 0);
`ifdef ONLINE_RES_OVF_EN
    check_output("ovf/set", 8'(bus.res_ovf), 8'd1);
`endif
    for (int i = 0; i < 3; i++)
      apply_stimulus(0, 1, 5'b00000, 5'b00000, 0, 2'b00);
    check_output("ovf_op/done", 8'(bus.done), 8'd1);
    apply_stimulus(0, 0, 5'b00000, 5'b00000, 0, 2'b00);
`ifdef ONLINE_RES_OVF_EN
    check_output("ovf/held", 8'(bus.res_ovf), 8'd1);
`endif
    apply_stimulus(1, 0, 5'b00000, 5'b00000, 0, 2'b00);
`ifdef ONLINE_RES_OVF_EN
    check_output("ovf/cleared", 8'(bus.res_ovf), 8'd0);
`endif

    // Asynchronous reset in the middle of RUN, then a clean restart.
    apply_stimulus(0, 1, 5'b00000, 5'b00000, 0, 2'b00);
    apply_stimulus(0, 1, 5'b00000, 5'b00000, 0, 2'b00);
    apply_stimulus(0, 1, 5'b01000, 5'b00000, 0, 2'b10);
    check_all("pre_reset", 5'b00001, 5'b00000, 2'b10, 1, 1, 0);
    #2 asyn_reset = 1'b1;
    #1;
    check_all("mid_reset", 5'b00000, 5'b00000, 2'b00, 0, 0, 0);
    @(posedge clk);
    #1 asyn_reset = 1'b0;
    apply_stimulus(0, 1, 5'b01000, 5'b00000, 0, 2'b10);
    check_all("idle_after_reset", 5'b00000, 5'b00000, 2'b00, 0, 0, 0);
    apply_stimulus(1, 0, 5'b00000, 5'b00000, 0, 2'b00);
    check_all("restart", 5'b00000, 5'b00000, 2'b00, 0, 1, 0);
    apply_stimulus(0, 1, 5'b00000, 5'b00000, 0, 2'b00);
    apply_stimulus(0, 1, 5'b00000, 5'b00000, 0, 2'b00);
    apply_stimulus(0, 1, 5'b00000, 5'b00110, 1, 2'b00);
    check_all("restart_run", 5'b00000, 5'b11100, 2'b01, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
